// File: rtl/rf_pkg.sv
// Shared definitions for the ND-120 register-file / IDB access controller:
// default geometry, controller state encoding and register index names.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_LEVELS = 16;
  localparam int RF_REGS   = 8;
  localparam int RF_ADDR_W = 7;
  localparam int RF_DEPTH  = RF_LEVELS * RF_REGS;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'b00,
    ST_IDLE    = 2'b01,
    ST_WSTROBE = 2'b10
  } rf_state_e;

  // Register order within one program level.
  typedef enum logic [2:0] {
    REG_P   = 3'd0,
    REG_X   = 3'd1,
    REG_T   = 3'd2,
    REG_A   = 3'd3,
    REG_D   = 3'd4,
    REG_L   = 3'd5,
    REG_STS = 3'd6,
    REG_B   = 3'd7
  } rf_reg_e;

  // Flat word address: program level selects the upper bits.
  function automatic logic [RF_ADDR_W-1:0] rf_addr(input logic [3:0] pil,
                                                   input logic [2:0] rfa);
    return {pil, rfa};
  endfunction

endpackage

// File: rtl/rf_idb_ctl_storage.sv
// Register-file word array: synchronous single write port, asynchronous read.
module rf_storage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array itself has no reset; the controller's CLEAR sweep zeroes
  // it one word per cycle, which keeps this mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rf_idb_ctl.sv
// Register-file access controller: IDB read sequencing with write-buffer
// bypass, two-cycle buffered writes and a post-reset clearing sweep.
module rf_idb_ctl
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int LEVELS = RF_LEVELS,
  parameter int REGS   = RF_REGS
) (
  input  logic                       CK,
  input  logic                       RESET,
  input  logic                       RRF_n,
  input  logic                       ERF_n,
  input  logic                       WRTRF,
  input  logic [$clog2(LEVELS)-1:0]  PIL,
  input  logic [$clog2(REGS)-1:0]    RFA,
  input  logic [DATA_W-1:0]          IDB_IN,
  output logic [DATA_W-1:0]          IDB_OUT,
  output logic                       IDB_OE,
  output logic                       BUSY,
  output logic                       WR_DONE
);

  localparam int ADDR_W = $clog2(LEVELS) + $clog2(REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEVELS * REGS - 1);

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [ADDR_W-1:0] addr;
  logic              rd_req;
  logic              wr_accept;
  logic              bypass_hit;
  logic [DATA_W-1:0] store_rdata;
  logic [DATA_W-1:0] rd_val;

  logic              store_we;
  logic [ADDR_W-1:0] store_waddr;
  logic [DATA_W-1:0] store_wdata;

  assign addr       = {PIL, RFA};
  assign rd_req     = !RRF_n && !ERF_n;
  assign wr_accept  = (state == ST_IDLE) && !ERF_n && WRTRF && !BUSY;
  assign bypass_hit = wb_valid && (wb_addr == addr);

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_val = store_rdata;
    if (state == ST_CLEAR) rd_val = '0;
    else if (bypass_hit)   rd_val = wb_data;
  end

  // Sweep and commit share the single write port; RESET blocks a commit
  // that would otherwise land in the same cycle.
  always_comb begin
    store_we    = 1'b0;
    store_waddr = wb_addr;
    store_wdata = wb_data;
    if (!RESET) begin
      if (state == ST_CLEAR) begin
        store_we    = 1'b1;
        store_waddr = clr_cnt;
        store_wdata = '0;
      end else if (state == ST_WSTROBE && wb_valid) begin
        store_we    = 1'b1;
      end
    end
  end

  rf_storage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_storage (
    .clk  (CK),
    .we   (store_we),
    .waddr(store_waddr),
    .wdata(store_wdata),
    .raddr(addr),
    .rdata(store_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values regardless of statement order.
  always_ff @(posedge CK) begin
    if (RESET) begin
      state    <= ST_CLEAR;
      clr_cnt  <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      BUSY     <= 1'b1;
      WR_DONE  <= 1'b0;
      IDB_OE   <= 1'b0;
      IDB_OUT  <= '0;
    end else begin
      IDB_OE  <= rd_req;
      if (rd_req) IDB_OUT <= rd_val;
      WR_DONE <= 1'b0;

      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (wr_accept) begin
            wb_addr  <= addr;
            wb_data  <= IDB_IN;
            wb_valid <= 1'b1;
            state    <= ST_WSTROBE;
            BUSY     <= 1'b1;
            WR_DONE  <= 1'b1;
          end
        end
        ST_WSTROBE: begin
          wb_valid <= 1'b0;
          state    <= ST_IDLE;
          BUSY     <= 1'b0;
        end
        default: begin
          state    <= ST_CLEAR;
          clr_cnt  <= '0;
          wb_valid <= 1'b0;
          BUSY     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_idb_ctl.sv
// Self-checking bench for rf_idb_ctl: directed vector table, multi-cycle
// corner sequences and a randomized run against a visible-memory model.
module tb_rf_idb_ctl;

  logic        CK = 1'b0;
  logic        RESET;
  logic        RRF_n, ERF_n, WRTRF;
  logic [3:0]  PIL;
  logic [2:0]  RFA;
  logic [15:0] IDB_IN;
  logic [15:0] IDB_OUT;
  logic        IDB_OE, BUSY, WR_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  rf_idb_ctl dut (
    .CK     (CK),
    .RESET  (RESET),
    .RRF_n  (RRF_n),
    .ERF_n  (ERF_n),
    .WRTRF  (WRTRF),
    .PIL    (PIL),
    .RFA    (RFA),
    .IDB_IN (IDB_IN),
    .IDB_OUT(IDB_OUT),
    .IDB_OE (IDB_OE),
    .BUSY   (BUSY),
    .WR_DONE(WR_DONE)
  );

  always #5 CK = ~CK;

  typedef struct {
    string       name;
    logic        rrf_n, erf_n, wrtrf;
    logic [3:0]  pil;
    logic [2:0]  rfa;
    logic [15:0] din;
    logic        exp_oe;
    logic [15:0] exp_out;
    logic        exp_busy, exp_done;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t v(input string name, input logic rrf_n, erf_n, wrtrf,
                             input logic [3:0] pil, input logic [2:0] rfa,
                             input logic [15:0] din, input logic exp_oe,
                             input logic [15:0] exp_out,
                             input logic exp_busy, exp_done);
    vec_t r;
    r.name = name; r.rrf_n = rrf_n; r.erf_n = erf_n; r.wrtrf = wrtrf;
    r.pil = pil; r.rfa = rfa; r.din = din; r.exp_oe = exp_oe;
    r.exp_out = exp_out; r.exp_busy = exp_busy; r.exp_done = exp_done;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic rrf_n, erf_n, wrtrf, input logic [3:0] pil,
                       input logic [2:0] rfa, input logic [15:0] din);
    RRF_n = rrf_n; ERF_n = erf_n; WRTRF = wrtrf; PIL = pil; RFA = rfa; IDB_IN = din;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 16'h0000);
  endtask

  // Counts cycles with BUSY high after the reset edge; also reports any WR_DONE.
  task automatic wait_sweep(input string tag);
    int  n = 0;
    bit  done_seen = 0;
    while (BUSY === 1'b1 && n < 300) begin
      tick();
      n++;
      if (WR_DONE === 1'b1) done_seen = 1;
    end
    check({tag, "_busy_len"}, n, 128);
    check({tag, "_no_done"}, done_seen, 0);
  endtask

  task automatic do_reset(input string tag);
    idle();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check({tag, "_rst_busy"}, BUSY, 1);
    check({tag, "_rst_oe"}, IDB_OE, 0);
    check({tag, "_rst_out"}, IDB_OUT, 0);
    check({tag, "_rst_done"}, WR_DONE, 0);
    wait_sweep(tag);
  endtask

  task automatic read_check(input string name, input logic [3:0] pil,
                            input logic [2:0] rfa, input logic [15:0] exp);
    drive(1'b0, 1'b0, 1'b0, pil, rfa, 16'h0000);
    tick();
    check({name, "_oe"}, IDB_OE, 1);
    check(name, IDB_OUT, exp);
    idle();
  endtask

  logic [15:0] shadow [128];
  logic [15:0] bp_data [6];

  initial begin
    RESET = 1'b1;
    idle();

    // Reset sweep.
    do_reset("sweep1");

    // Directed vectors, starting in IDLE with all words zero.
    vecs[0]  = v("rd_15_7",     0, 0, 0, 4'd15, 3'd7, 16'h0000, 1, 16'h0000, 0, 0);
    vecs[1]  = v("idle_a",      1, 1, 0, 4'd0,  3'd0, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[2]  = v("wr_3_5",      1, 0, 1, 4'd3,  3'd5, 16'hA5C3, 0, 16'h0000, 1, 1);
    vecs[3]  = v("idle_b",      1, 1, 0, 4'd0,  3'd0, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[4]  = v("rd_3_5",      0, 0, 0, 4'd3,  3'd5, 16'h0000, 1, 16'hA5C3, 0, 0);
    vecs[5]  = v("rd_4_5",      0, 0, 0, 4'd4,  3'd5, 16'h0000, 1, 16'h0000, 0, 0);
    vecs[6]  = v("wr_2a_1234",  1, 0, 1, 4'd5,  3'd2, 16'h1234, 0, 16'h0000, 1, 1);
    vecs[7]  = v("bypass_rd",   0, 0, 0, 4'd5,  3'd2, 16'h0000, 1, 16'h1234, 0, 0);
    vecs[8]  = v("wr_2a_1111",  1, 0, 1, 4'd5,  3'd2, 16'h1111, 0, 16'h1234, 1, 1);
    vecs[9]  = v("idle_c",      1, 1, 0, 4'd0,  3'd0, 16'h0000, 0, 16'h1234, 0, 0);
    vecs[10] = v("rdwr_same",   0, 0, 1, 4'd5,  3'd2, 16'h2222, 1, 16'h1111, 1, 1);
    vecs[11] = v("rd_after_wr", 0, 0, 0, 4'd5,  3'd2, 16'h0000, 1, 16'h2222, 0, 0);
    vecs[12] = v("rd_stored",   0, 0, 0, 4'd5,  3'd2, 16'h0000, 1, 16'h2222, 0, 0);
    vecs[13] = v("erf_high",    0, 1, 1, 4'd5,  3'd2, 16'hDEAD, 0, 16'h2222, 0, 0);
    vecs[14] = v("rd_no_wr",    0, 0, 0, 4'd5,  3'd2, 16'h0000, 1, 16'h2222, 0, 0);
    vecs[15] = v("rd_3_5_again",0, 0, 0, 4'd3,  3'd5, 16'h0000, 1, 16'hA5C3, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rrf_n, vecs[i].erf_n, vecs[i].wrtrf,
            vecs[i].pil, vecs[i].rfa, vecs[i].din);
      tick();
      check({vecs[i].name, "_oe"},   IDB_OE,  vecs[i].exp_oe);
      check({vecs[i].name, "_out"},  IDB_OUT, vecs[i].exp_out);
      check({vecs[i].name, "_busy"}, BUSY,    vecs[i].exp_busy);
      check({vecs[i].name, "_done"}, WR_DONE, vecs[i].exp_done);
    end
    idle();
    tick();

    // Back-pressure: WRTRF held for 6 cycles, only alternate cycles accept.
    begin
      int commits = 0;
      for (int i = 0; i < 6; i++) begin
        bp_data[i] = 16'h5000 + 16'(i) * 16'h0101;
        drive(1'b1, 1'b0, 1'b1, 4'd2, 3'(i), bp_data[i]);
        tick();
        check($sformatf("bp_done_%0d", i), WR_DONE, (i % 2 == 0) ? 1 : 0);
        if (WR_DONE === 1'b1) commits++;
      end
      idle();
      tick();
      check("bp_commits", commits, 3);
      for (int i = 0; i < 6; i++)
        read_check($sformatf("bp_rd_%0d", i), 4'd2, 3'(i),
                   (i % 2 == 0) ? bp_data[i] : 16'h0000);
    end

    // Reset in the WSTROBE cycle discards the buffered write.
    drive(1'b1, 1'b0, 1'b1, 4'd6, 3'd3, 16'hBEEF);
    tick();
    check("mw_accept_done", WR_DONE, 1);
    idle();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("mw_rst_done", WR_DONE, 0);
    check("mw_rst_busy", BUSY, 1);
    wait_sweep("mw");
    read_check("mw_target", 4'd6, 3'd3, 16'h0000);
    read_check("mw_old_word", 4'd3, 3'd5, 16'h0000);

    // Randomized run. The model is a memory where an accepted write becomes
    // visible to reads from the next cycle on, and accepts need a gap cycle.
    for (int a = 0; a < 128; a++) shadow[a] = 16'h0000;
    begin
      bit          prev_acc = 0;
      logic [15:0] exp_out  = IDB_OUT;
      for (int c = 0; c < 400; c++) begin
        logic        rrf_n, erf_n, wrtrf, rd, acc;
        logic [3:0]  pil;
        logic [2:0]  rfa;
        logic [15:0] din;
        int          a;
        erf_n = ($urandom_range(0, 7) == 0);
        rrf_n = $urandom_range(0, 1) == 1;
        wrtrf = $urandom_range(0, 2) != 0;
        pil   = 4'($urandom_range(0, 1));
        rfa   = 3'($urandom_range(0, 7));
        din   = 16'($urandom);
        a     = pil * 8 + rfa;
        rd    = !rrf_n && !erf_n;
        acc   = !erf_n && wrtrf && !prev_acc;
        if (rd) exp_out = shadow[a];
        if (acc) shadow[a] = din;
        prev_acc = acc;
        drive(rrf_n, erf_n, wrtrf, pil, rfa, din);
        tick();
        check($sformatf("rnd%0d_oe", c),   IDB_OE,  rd);
        check($sformatf("rnd%0d_out", c),  IDB_OUT, exp_out);
        check($sformatf("rnd%0d_busy", c), BUSY,    acc);
        check($sformatf("rnd%0d_done", c), WR_DONE, acc);
      end
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
